alu_secuencial: RTL
===================

# alu_secuencial

Registered, multi-cycle successor of the combinational ALU. Accepts an operation and two N-bit operands through a valid/ready handshake. Executes add, subtract, logic and shift operations in one cycle, and multiply, divide and modulo iteratively in N cycles. Presents a 2N-bit result plus four flags through a valid/ready output that holds under backpressure. It sits between the operand/opcode source (switch/register front end) and the display/result consumer.

## Interface
- N, default 4, operand width; legal N >= 2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request (high only in IDLE)
- op_select  input  4  operation code
- operand1  input  N  first operand (unsigned)
- operand2  input  N  second operand / shift amount (unsigned)
- out_valid  output  1  resultado/banderas valid
- out_ready  input  1  consumer accepts the result
- resultado  output  2N  result, zero-extended
- banderas  output  4  [3] V overflow/error, [2] C carry, [1] Z zero, [0] B borrow

## Operation
- Accept: in_valid && in_ready at a clk edge. op_select and both operands are latched; inputs are ignored afterwards until the next accept.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> DONE on accept of a single-cycle op.
  - IDLE -> BUSY on accept of 2/3/4.
  - BUSY -> DONE when the iteration counter reaches N.
  - DONE -> IDLE when out_ready is high.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- Ops and results (all zero-extended to 2N bits):
  - 0 add: operand1 + operand2 as N+1 bits. C = bit N. V = signed overflow of the N-bit sum.
  - 1 sub: (operand1 - operand2) mod 2^N. B = operand1 < operand2. V = signed overflow.
  - 2 mul: unsigned shift-add product, 2N bits. V = upper N bits nonzero.
  - 3 div: restoring quotient, N bits.
  - 4 mod: restoring remainder, N bits.
  - 5 and, 6 or, 7 xor: bitwise, N bits.
  - 8 shl: operand1 << operand2 kept as N+1 bits. C = bit N. Shift amount >= N+1 gives 0.
  - 9 shr: logical operand1 >> operand2, N bits. Shift amount >= N gives 0.
  - 10-15 reserved: result 0, V = 1.
- Division by zero: no special datapath. Restoring iteration naturally yields quotient all-ones and remainder = operand1. V = 1 for ops 3 and 4.
- Z = (2N-bit resultado == 0), evaluated for every op.
- Flags not listed for an op are 0.

## Timing
- Reset (asynchronous, any state): state IDLE, resultado 0, banderas 0, out_valid 0, in_ready 1, iteration counter 0. An operation in flight is discarded.
- Latency is counted from the accept edge to the first edge with out_valid high:
  - Single-cycle ops: 1 cycle.
  - mul/div/mod: N+1 cycles (N BUSY cycles + 1 write to DONE).
- resultado and banderas are registered. They update only on the transition into DONE and stay stable while out_valid is high.
- out_ready high in the first DONE cycle gives one cycle of out_valid; the block is back in IDLE the next cycle.
- Peak throughput is one single-cycle op every 2 cycles.
- in_valid asserted outside IDLE is not accepted; the requester must hold it.
- out_ready is ignored outside DONE.
- Iteration counter width: $clog2(N)+1.

## Structure
- Package alu_pkg contains:
  - op_e enum: OP_ADD .. OP_SHR, with reserved codes.
  - state_e enum: IDLE, BUSY, DONE.
  - Flag index constants: FLG_V=3, FLG_C=2, FLG_Z=1, FLG_B=0.
- Sub-module alu_iter_muldiv #(N):
  - Inputs: start, mode (mul/div), a, b.
  - Outputs: done pulse after N cycles, 2N-bit product or {remainder, quotient}.
  - Owns the iteration counter and shift registers.
- The top level owns the handshake FSM, the single-cycle datapath, flag generation and the output registers.

## Test plan
- N=4, add 9+8 -> resultado 8'h11, banderas 4'b1100 (V=1, C=1), out_valid exactly 1 cycle after accept.
- N=4, sub 3-5 -> resultado 8'h0E, B=1, V=0, Z=0. Sub 6-6 -> resultado 0, Z=1.
- N=4, mul 15*15 -> resultado 8'hE1, V=1, out_valid exactly 5 cycles after accept, in_ready low throughout.
- N=4, div 13/4 -> 8'h03; mod 13%4 -> 8'h01. Div 7/0 -> 8'h0F with V=1; mod 7%0 -> 8'h07 with V=1.
- Backpressure: hold out_ready low 3 cycles in DONE while driving new in_valid and changing operands. Required response: resultado/banderas unchanged, no new accept, return to IDLE the cycle after out_ready rises. Reserved op 4'b1100 -> resultado 0, Z=1, V=1.
- Assert rst during BUSY cycle 2 of a mul. Required response: all outputs at reset values immediately (asynchronously), in_ready=1 after release, and a following add 1+1 returns 8'h02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag index definitions for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_MUL    = 4'd2,
    OP_DIV    = 4'd3,
    OP_MOD    = 4'd4,
    OP_AND    = 4'd5,
    OP_OR     = 4'd6,
    OP_XOR    = 4'd7,
    OP_SHL    = 4'd8,
    OP_SHR    = 4'd9,
    OP_RSV10  = 4'd10,
    OP_RSV11  = 4'd11,
    OP_RSV12  = 4'd12,
    OP_RSV13  = 4'd13,
    OP_RSV14  = 4'd14,
    OP_RSV15  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLG_V = 3;
  localparam int FLG_C = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_B = 0;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// N-cycle shift-add multiplier / restoring divider. The final iteration's value is
// presented on result_o alongside done_o so the caller can latch it on that same edge.
module alu_iter_muldiv #(
  parameter int N = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           mode_i,    // 0 = multiply, 1 = divide
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           done_o,
  output logic [2*N-1:0] result_o
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic           busy_q, busy_d;
  logic           mode_q, mode_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;      // mul: running product; div: {remainder, quotient}
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d; // mul: multiplier bits; div: divisor

  logic [2*N-1:0] acc_mul;
  logic [N:0]     shifted, trial;
  logic           ge;

  always_comb begin
    acc_mul = acc_q + (mplier_q[0] ? mcand_q : '0);
    // Division by zero needs no special case: every trial succeeds, leaving
    // quotient all-ones and the dividend shifted wholly into the remainder.
    shifted = {acc_q[2*N-1:N], acc_q[N-1]};
    trial   = shifted - {1'b0, mplier_q};
    ge      = shifted >= {1'b0, mplier_q};

    busy_d   = busy_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;

    if (start_i) begin
      busy_d   = 1'b1;
      mode_d   = mode_i;
      cnt_d    = '0;
      acc_d    = mode_i ? {{N{1'b0}}, a_i} : '0;
      mcand_d  = {{N{1'b0}}, a_i};
      mplier_d = b_i;
    end else if (busy_q) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) busy_d = 1'b0;
      if (mode_q) begin
        acc_d = {(ge ? trial[N-1:0] : shifted[N-1:0]), acc_q[N-2:0], ge};
      end else begin
        acc_d    = acc_mul;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end
  end

  assign done_o   = busy_q && (cnt_q == LAST);
  assign result_o = acc_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_secuencial.sv
// Registered multi-cycle ALU: valid/ready request in, held valid/ready result out.
// Single-cycle ops resolve on the accept edge; mul/div/mod go through alu_iter_muldiv.
module alu_secuencial
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     op_select,
  input  logic [N-1:0]   operand1,
  input  logic [N-1:0]   operand2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] resultado,
  output logic [3:0]     banderas
);

  localparam int W = 2 * N;

  state_e         state_q, state_d;
  logic [W-1:0]   res_q, res_d;
  logic [3:0]     flg_q, flg_d;
  logic [3:0]     op_q, op_d;
  logic           bz_q, bz_d;

  logic           accept, md_start, md_done;
  logic [W-1:0]   md_res;

  logic [N:0]     sum, shl;
  logic [N-1:0]   diff;
  logic [W-1:0]   sc_res, it_res;
  logic [3:0]     sc_flg, it_flg;

  assign accept   = (state_q == IDLE) && in_valid;
  assign md_start = accept && is_iter(op_select);

  alu_iter_muldiv #(.N(N)) u_muldiv (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (md_start),
    .mode_i   (op_select != OP_MUL),
    .a_i      (operand1),
    .b_i      (operand2),
    .done_o   (md_done),
    .result_o (md_res)
  );

  always_comb begin
    sum    = {1'b0, operand1} + {1'b0, operand2};
    diff   = operand1 - operand2;
    shl    = {1'b0, operand1} << operand2;
    sc_res = '0;
    sc_flg = '0;
    case (op_e'(op_select))
      OP_ADD: begin
        sc_res        = W'(sum);
        sc_flg[FLG_C] = sum[N];
        sc_flg[FLG_V] = (operand1[N-1] == operand2[N-1]) && (sum[N-1] != operand1[N-1]);
      end
      OP_SUB: begin
        sc_res        = W'(diff);
        sc_flg[FLG_B] = operand1 < operand2;
        sc_flg[FLG_V] = (operand1[N-1] != operand2[N-1]) && (diff[N-1] != operand1[N-1]);
      end
      OP_AND: sc_res = W'(operand1 & operand2);
      OP_OR:  sc_res = W'(operand1 | operand2);
      OP_XOR: sc_res = W'(operand1 ^ operand2);
      OP_SHL: begin
        sc_res        = W'(shl);
        sc_flg[FLG_C] = shl[N];
      end
      OP_SHR: sc_res = W'(operand1 >> operand2);
      default: sc_flg[FLG_V] = 1'b1;  // reserved codes (iterative ops never take this path)
    endcase
    sc_flg[FLG_Z] = (sc_res == '0);
  end

  always_comb begin
    it_res = '0;
    it_flg = '0;
    case (op_e'(op_q))
      OP_MUL: begin
        it_res        = md_res;
        it_flg[FLG_V] = |md_res[W-1:N];
      end
      OP_DIV: begin
        it_res        = W'(md_res[N-1:0]);
        it_flg[FLG_V] = bz_q;
      end
      OP_MOD: begin
        it_res        = W'(md_res[W-1:N]);
        it_flg[FLG_V] = bz_q;
      end
      default: it_flg[FLG_V] = 1'b1;
    endcase
    it_flg[FLG_Z] = (it_res == '0);
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    flg_d   = flg_q;
    op_d    = op_q;
    bz_d    = bz_q;
    case (state_q)
      IDLE: if (in_valid) begin
        op_d = op_select;
        bz_d = (operand2 == '0);
        if (is_iter(op_select)) begin
          state_d = BUSY;
        end else begin
          state_d = DONE;
          res_d   = sc_res;
          flg_d   = sc_flg;
        end
      end
      BUSY: if (md_done) begin
        state_d = DONE;
        res_d   = it_res;
        flg_d   = it_flg;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      flg_q   <= '0;
      op_q    <= '0;
      bz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      op_q    <= op_d;
      bz_q    <= bz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign resultado = res_q;
  assign banderas  = flg_q;

endmodule
